// File: rtl/display_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver for a processor debug display.
// Captures a 16-bit result (and optionally the PC low byte) on each rising edge
// of an asynchronous step_tick. The captured values are scanned out on active-low
// cathodes and anodes.
// Optional feature: define DISPLAY_PC_EN to add a second display page that shows
// "P" + blank + PC byte. In that build the page alternates every PAGE_STEPS steps.
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PAGE_STEPS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_tick,
  input  logic [15:0] result_in,
  input  logic [7:0]  pc_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned    CntW   = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegP     = 7'b0001100;

  logic            r_sync1, r_sync2, r_hist;
  logic            w_step_edge;
  logic [15:0]     r_res_hold;
  logic [CntW-1:0] r_refresh_cnt;
  logic            w_refresh_tc;
  logic [1:0]      r_digit;
  logic [3:0]      w_res_nib;
  logic [6:0]      w_seg_nxt;
  logic            w_dp_nxt;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;
  logic            r_dp;

  // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer plus history flop, used for rising-edge detection of step_tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= step_tick;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_step_edge  = r_sync2 & ~r_hist;
  assign w_refresh_tc = (r_refresh_cnt == CntMax);

  // Refresh divider; the digit index advances when the divider wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh_cnt <= '0;
      r_digit       <= 2'd0;
    end else if (w_refresh_tc) begin
      r_refresh_cnt <= '0;
      r_digit       <= r_digit + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Result hold register, written only on a detected step edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_hold <= '0;
    end else if (w_step_edge) begin
      r_res_hold <= result_in;
    end
  end

  assign w_res_nib = r_res_hold[{r_digit, 2'b00} +: 4];

`ifdef DISPLAY_PC_EN
  typedef enum logic {StShowRes, StShowPc} page_e;

  localparam logic [7:0] PageMax = 8'(PAGE_STEPS - 1);

  page_e      r_state;
  logic [7:0] r_page_cnt;
  logic [7:0] r_pc_hold;

  // Page FSM: toggles after PAGE_STEPS step edges and captures the PC on every step edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StShowRes;
      r_page_cnt <= 8'd0;
      r_pc_hold  <= 8'd0;
    end else if (w_step_edge) begin
      r_pc_hold <= pc_in;
      if (r_page_cnt == PageMax) begin
        r_page_cnt <= 8'd0;
        r_state    <= (r_state == StShowRes) ? StShowPc : StShowRes;
      end else begin
        r_page_cnt <= r_page_cnt + 8'd1;
      end
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc_in;
`endif

  // Glyph and decimal point for the digit currently selected
  always_comb begin
    w_seg_nxt = hex7(w_res_nib);
    w_dp_nxt  = 1'b1;
`ifdef DISPLAY_PC_EN
    if (r_state == StShowPc) begin
      unique case (r_digit)
        2'd0: begin
          w_seg_nxt = hex7(r_pc_hold[3:0]);
          w_dp_nxt  = 1'b0;
        end
        2'd1:    w_seg_nxt = hex7(r_pc_hold[7:4]);
        2'd2:    w_seg_nxt = SegBlank;
        default: w_seg_nxt = SegP;
      endcase
    end
`endif
  end

  // Output registers share one digit index and page, so anode and cathodes switch together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= SegBlank;
      r_an  <= 4'hF;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= ~(4'b0001 << r_digit);
      r_dp  <= w_dp_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver (REFRESH_DIV=4, PAGE_STEPS=2).
// A cycle-level reference model predicts seg/an/dp from the scan arithmetic and
// the step-capture schedule. Directed scenarios add hand-computed literal checks.
`timescale 1ns/1ps
module tb_display_scan_driver;

  localparam int unsigned RDIV   = 4;
  localparam int unsigned PSTEPS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_tick = 1'b0;
  logic [15:0] result_in = 16'h0000;
  logic [7:0]  pc_in = 8'h00;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_driver #(.REFRESH_DIV(RDIV), .PAGE_STEPS(PSTEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .step_tick (step_tick),
    .result_in (result_in),
    .pc_in     (pc_in),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          edge_n;
    logic [15:0] r;
    logic [7:0]  p;
  } cap_t;

  cap_t        pend[$];
  cap_t        m_c;
  int          cyc = 0;
  logic [15:0] m_res;
  logic [7:0]  m_pc;
  int          m_steps;
  logic        m_prev;
  int          m_d;
  bit          m_pcpage;
  logic [6:0]  e_seg = 7'h7F;
  logic [3:0]  e_an = 4'hF;
  logic        e_dp = 1'b1;

  // Edge n after reset release lights digit ((n-1)/RDIV)%4 using holds as they were
  // before edge n; a rise first seen at edge k is captured at edge k+2.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      cyc = 0; m_res = '0; m_pc = '0; m_steps = 0; m_prev = 1'b0;
      pend.delete();
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
    end else begin
      cyc++;
      m_d = ((cyc - 1) / RDIV) % 4;
`ifdef DISPLAY_PC_EN
      m_pcpage = ((m_steps / PSTEPS) % 2) == 1;
`else
      m_pcpage = 1'b0;
`endif
      e_an = ~(4'b0001 << m_d);
      e_dp = !(m_pcpage && m_d == 0);
      if (!m_pcpage)    e_seg = hex_tab[(m_res >> (4 * m_d)) & 16'hF];
      else if (m_d == 0) e_seg = hex_tab[m_pc[3:0]];
      else if (m_d == 1) e_seg = hex_tab[m_pc[7:4]];
      else if (m_d == 2) e_seg = 7'h7F;
      else               e_seg = 7'b0001100;
      while (pend.size() > 0 && pend[0].edge_n == cyc) begin
        m_c = pend.pop_front();
        m_res = m_c.r;
        m_pc  = m_c.p;
        m_steps++;
      end
      if (step_tick && !m_prev) begin
        m_c.edge_n = cyc + 2;
        m_c.r = result_in;
        m_c.p = pc_in;
        pend.push_back(m_c);
      end
      m_prev = step_tick;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("rst_seg", {9'd0, seg}, 16'h7F);
      check("rst_an",  {12'd0, an}, 16'hF);
      check("rst_dp",  {15'd0, dp}, 16'h1);
    end else begin
      check("model_seg", {9'd0, seg}, {9'd0, e_seg});
      check("model_an",  {12'd0, an}, {12'd0, e_an});
      check("model_dp",  {15'd0, dp}, {15'd0, e_dp});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_an(input logic [3:0] tgt, input string name);
    int k;
    k = 0;
    while (an !== tgt && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (an !== tgt) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for an=%0h, got %0h", name, tgt, an);
    end
  endtask

  task automatic pulse();
    @(negedge clk);
    #2 step_tick = 1'b1;
    repeat (4) @(negedge clk);
    #2 step_tick = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int tgt;
  int k;

  initial begin
    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    check("hold_rst_seg", {9'd0, seg}, 16'h7F);
    check("hold_rst_an",  {12'd0, an}, 16'hF);
    check("hold_rst_dp",  {15'd0, dp}, 16'h1);
    #2 rst = 1'b1;
    @(negedge clk);
    check("first_an",  {12'd0, an}, 16'hE);
    check("first_seg", {9'd0, seg}, 16'h40);
    check("first_dp",  {15'd0, dp}, 16'h1);

    // Free-running scan: E,D,B,7 each for 4 cycles, then wrap to E
    for (int i = 0; i < 17; i++) begin
      check("scan_an", {12'd0, an}, {12'd0, an_seq[(i / 4) % 4]});
      @(negedge clk);
    end

    // One step pulse with result 3A7F
    result_in = 16'h3A7F;
    pulse();
    wait_an(4'hE, "res_d0"); check("res_d0_seg", {9'd0, seg}, 16'h0E);
    wait_an(4'hD, "res_d1"); check("res_d1_seg", {9'd0, seg}, 16'h78);
    wait_an(4'hB, "res_d2"); check("res_d2_seg", {9'd0, seg}, 16'h08);
    wait_an(4'h7, "res_d3"); check("res_d3_seg", {9'd0, seg}, 16'h30);

    // Two pulses with pc 5C
    pc_in = 8'h5C;
    pulse();
    pulse();
`ifdef DISPLAY_PC_EN
    wait_an(4'h7, "pc_d3"); check("pc_d3_seg", {9'd0, seg}, 16'h0C);
    wait_an(4'hB, "pc_d2"); check("pc_d2_seg", {9'd0, seg}, 16'h7F);
    wait_an(4'hD, "pc_d1"); check("pc_d1_seg", {9'd0, seg}, 16'h12);
    wait_an(4'hE, "pc_d0"); check("pc_d0_seg", {9'd0, seg}, 16'h46);
    check("pc_d0_dp", {15'd0, dp}, 16'h0);
    pulse();
    pulse();
`endif
    wait_an(4'hE, "back_d0"); check("back_d0_seg", {9'd0, seg}, 16'h0E);
    check("back_d0_dp", {15'd0, dp}, 16'h1);
    wait_an(4'h7, "back_d3"); check("back_d3_seg", {9'd0, seg}, 16'h30);

    // Step edge coinciding with the digit 3->0 advance
    result_in = 16'h1234;
    pc_in     = 8'hA9;
    k = 0;
    while ((cyc % 16) != 13 && k < 40) begin
      @(negedge clk);
      k++;
    end
    #2 step_tick = 1'b1;
    tgt = cyc + 3;
    k = 0;
    while (cyc < tgt && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("align_old_an",  {12'd0, an}, 16'h7);
    check("align_old_seg", {9'd0, seg}, 16'h30);
    @(negedge clk);
    check("align_new_an", {12'd0, an}, 16'hE);
`ifdef DISPLAY_PC_EN
    // Sixth step edge also toggles to the PC page in the same cycle
    check("align_new_seg", {9'd0, seg}, 16'h10);
    check("align_new_dp",  {15'd0, dp}, 16'h0);
`else
    check("align_new_seg", {9'd0, seg}, 16'h19);
    check("align_new_dp",  {15'd0, dp}, 16'h1);
`endif
    repeat (2) @(negedge clk);
    #2 step_tick = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-scan (on the PC page when that page exists)
    wait_an(4'h7, "pre_rst_d3");
`ifdef DISPLAY_PC_EN
    check("pre_rst_seg", {9'd0, seg}, 16'h0C);
`else
    check("pre_rst_seg", {9'd0, seg}, 16'h79);
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_seg", {9'd0, seg}, 16'h7F);
    check("async_rst_an",  {12'd0, an}, 16'hF);
    check("async_rst_dp",  {15'd0, dp}, 16'h1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rel_an",  {12'd0, an}, 16'hE);
    check("rel_seg", {9'd0, seg}, 16'h40);
    check("rel_dp",  {15'd0, dp}, 16'h1);
    wait_an(4'h7, "rel_d3");
    check("rel_d3_seg", {9'd0, seg}, 16'h40);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
